fb_pixel_writer: RTL

//  Writer side of the Cellular RAM framebuffer that the VGA pixel path reads by MemAdr.

---
 rtl/fb_pixel_writer_pkg.sv | 35 +++
 rtl/fb_pixel_writer_cram_async_write.sv | 118 +++++++++++
 rtl/fb_pixel_writer.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/fb_pixel_writer_pkg.sv
// Shared widths, state encodings and the pixel-index helper for the framebuffer writer.
package fb_pixel_writer_pkg;

   localparam int WR_CYCLES_DEF = 4;
   localparam int ADDR_W        = 26;
   localparam int DATA_W        = 16;
   localparam int COORD_W       = 11;
   localparam int IDX_W         = 22;
   localparam int CTR_W         = IDX_W - 1;
   localparam int CNT_W         = 8;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_REQ   = 3'd1,
      ST_SETUP = 3'd2,
      ST_WRITE = 3'd3,
      ST_HOLD  = 3'd4
   } wr_state_e;

   typedef enum logic [1:0] {
      TOP_IDLE = 2'd0,
      TOP_REQ  = 2'd1,
      TOP_XFER = 2'd2
   } top_state_e;

   // Linear pixel index y*width + x; two pixels share one 16-bit CRAM word.
   function automatic logic [IDX_W-1:0] pixel_index(
      input logic [COORD_W-1:0] x,
      input logic [COORD_W-1:0] y,
      input logic [IDX_W-1:0]   width
   );
      return (IDX_W'(y) * width) + IDX_W'(x);
   endfunction

endpackage

// File: rtl/fb_pixel_writer_cram_async_write.sv
// SETUP/WRITE/HOLD sequencer for one asynchronous CRAM write; a start in HOLD chains
// straight into the next SETUP so a fill keeps the bus without returning to idle.
module cram_async_write
   import fb_pixel_writer_pkg::*;
#(
   parameter int WR_CYCLES = WR_CYCLES_DEF
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic [1:0]        be_i,
   output logic              hold_o,
   output logic              done_o,
   output logic [ADDR_W-1:0] mem_adr_o,
   output logic [DATA_W-1:0] db_out_o,
   output logic              db_oe_o,
   output logic              mem_wr_n_o,
   output logic              cs_n_o,
   output logic              lb_n_o,
   output logic              ub_n_o
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WR_CYCLES - 1);

   wr_state_e         state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              load_s;
   logic [ADDR_W-1:0] adr_q;
   logic [DATA_W-1:0] dout_q;
   logic              db_oe_q, wr_n_q, cs_n_q, lb_n_q, ub_n_q, done_q;

   // Next-state and pulse-width counting for the write cycle.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      load_s  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               state_d = ST_SETUP;
               load_s  = 1'b1;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_SETUP: begin
            state_d = ST_WRITE;
            cnt_d   = {CNT_W{1'b0}};
         end
         ST_WRITE: begin
            if (cnt_q == CNT_LAST) begin
               state_d = ST_HOLD;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         ST_HOLD: begin
            if (start_i) begin
               state_d = ST_SETUP;
               load_s  = 1'b1;
            end else begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Registered CRAM pins, derived from the state being entered so they align with it.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         cnt_q   <= {CNT_W{1'b0}};
         adr_q   <= {ADDR_W{1'b0}};
         dout_q  <= {DATA_W{1'b0}};
         db_oe_q <= 1'b0;
         wr_n_q  <= 1'b1;
         cs_n_q  <= 1'b1;
         lb_n_q  <= 1'b1;
         ub_n_q  <= 1'b1;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         done_q  <= (state_q == ST_HOLD);
         cs_n_q  <= (state_d == ST_IDLE);
         db_oe_q <= (state_d != ST_IDLE);
         wr_n_q  <= (state_d != ST_WRITE);
         if (load_s) begin
            adr_q  <= addr_i;
            dout_q <= data_i;
            lb_n_q <= ~be_i[0];
            ub_n_q <= ~be_i[1];
         end else if (state_d == ST_IDLE) begin
            lb_n_q <= 1'b1;
            ub_n_q <= 1'b1;
         end else begin
            lb_n_q <= lb_n_q;
            ub_n_q <= ub_n_q;
         end
      end
   end

   assign hold_o     = (state_q == ST_HOLD);
   assign done_o     = done_q;
   assign mem_adr_o  = adr_q;
   assign db_out_o   = dout_q;
   assign db_oe_o    = db_oe_q;
   assign mem_wr_n_o = wr_n_q;
   assign cs_n_o     = cs_n_q;
   assign lb_n_o     = lb_n_q;
   assign ub_n_o     = ub_n_q;

endmodule

// File: rtl/fb_pixel_writer.sv
// Framebuffer writer: pixel handshake, pixel-to-word mapping, whole-screen clear and
// bus request around the CRAM write sequencer.
module fb_pixel_writer
   import fb_pixel_writer_pkg::*;
#(
   parameter int WIDTH     = 640,
   parameter int HEIGHT    = 480,
   parameter int BASE_WORD = 0,
   parameter int WR_CYCLES = WR_CYCLES_DEF
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                px_valid,
   output logic                px_ready,
   input  logic [COORD_W-1:0]  px_x,
   input  logic [COORD_W-1:0]  px_y,
   input  logic [7:0]          px_data,
   input  logic                clr_start,
   input  logic [7:0]          clr_colour,
   output logic                clr_busy,
   output logic                wr_done,
   output logic                err_oob,
   output logic                bus_req,
   input  logic                bus_gnt,
   output logic [ADDR_W-1:0]   MemAdr,
   output logic [DATA_W-1:0]   db_out,
   output logic                db_oe,
   output logic                MemWR,
   output logic                MemOE,
   output logic                RamCS,
   output logic                RamLB,
   output logic                RamUB,
   output logic                RamAdv,
   output logic                RamClk,
   output logic                RamCRE
);

   localparam logic [CTR_W-1:0]   CLR_LAST   = CTR_W'((WIDTH * HEIGHT) / 2 - 1);
   localparam logic [ADDR_W-1:0]  BASE_ADR   = ADDR_W'(BASE_WORD);
   localparam logic [IDX_W-1:0]   WIDTH_IDX  = IDX_W'(WIDTH);
   localparam logic [COORD_W-1:0] WIDTH_LIM  = COORD_W'(WIDTH);
   localparam logic [COORD_W-1:0] HEIGHT_LIM = COORD_W'(HEIGHT);

   top_state_e        state_q, state_d;
   logic              clr_active_q, clr_active_d;
   logic [7:0]        clr_colour_q, clr_colour_d;
   logic [CTR_W-1:0]  ctr_q, ctr_d;
   logic [ADDR_W-1:0] pix_adr_q, pix_adr_d;
   logic [DATA_W-1:0] pix_data_q, pix_data_d;
   logic [1:0]        pix_be_q, pix_be_d;
   logic              clr_busy_q, clr_busy_d;
   logic              err_oob_q, err_oob_d;
   logic              bus_req_q;

   logic              px_ready_s;
   logic [IDX_W-1:0]  idx_s;
   logic              oob_s;
   logic              seq_start_s, seq_hold_s;
   logic [ADDR_W-1:0] seq_adr_s;
   logic [DATA_W-1:0] seq_data_s;
   logic [1:0]        seq_be_s;

   // A clear request in the same cycle takes the slot, so the pixel is not accepted.
   assign px_ready_s = (state_q == TOP_IDLE) && !rst && !clr_start;
   assign idx_s      = pixel_index(px_x, px_y, WIDTH_IDX);
   assign oob_s      = (px_x >= WIDTH_LIM) || (px_y >= HEIGHT_LIM);

   // Request handling, clear word counter and sequencer launch.
   always_comb begin
      state_d      = state_q;
      clr_active_d = clr_active_q;
      clr_colour_d = clr_colour_q;
      ctr_d        = ctr_q;
      pix_adr_d    = pix_adr_q;
      pix_data_d   = pix_data_q;
      pix_be_d     = pix_be_q;
      clr_busy_d   = clr_busy_q;
      err_oob_d    = 1'b0;
      seq_start_s  = 1'b0;
      case (state_q)
         TOP_IDLE: begin
            if (clr_start) begin
               clr_active_d = 1'b1;
               clr_colour_d = clr_colour;
               ctr_d        = {CTR_W{1'b0}};
               clr_busy_d   = 1'b1;
               state_d      = TOP_REQ;
            end else if (px_valid && px_ready_s) begin
               if (oob_s) begin
                  err_oob_d = 1'b1;
                  state_d   = TOP_IDLE;
               end else begin
                  clr_active_d = 1'b0;
                  pix_adr_d    = BASE_ADR + ADDR_W'(idx_s[IDX_W-1:1]);
                  pix_data_d   = {px_data, px_data};
                  pix_be_d     = idx_s[0] ? 2'b10 : 2'b01;
                  state_d      = TOP_REQ;
               end
            end else begin
               state_d = TOP_IDLE;
            end
         end
         TOP_REQ: begin
            if (bus_gnt) begin
               seq_start_s = 1'b1;
               state_d     = TOP_XFER;
            end else begin
               state_d = TOP_REQ;
            end
         end
         TOP_XFER: begin
            if (seq_hold_s) begin
               if (clr_active_q && (ctr_q < CLR_LAST)) begin
                  ctr_d       = ctr_q + 21'd1;
                  seq_start_s = 1'b1;
               end else begin
                  clr_active_d = 1'b0;
                  clr_busy_d   = 1'b0;
                  state_d      = TOP_IDLE;
               end
            end else begin
               state_d = TOP_XFER;
            end
         end
         default: begin
            state_d = TOP_IDLE;
         end
      endcase

      if (clr_active_q) begin
         seq_adr_s  = BASE_ADR + ADDR_W'(ctr_d);
         seq_data_s = {clr_colour_q, clr_colour_q};
         seq_be_s   = 2'b11;
      end else begin
         seq_adr_s  = pix_adr_q;
         seq_data_s = pix_data_q;
         seq_be_s   = pix_be_q;
      end
   end

   // Control registers; bus_req covers every cycle outside IDLE, including HOLD.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= TOP_IDLE;
         clr_active_q <= 1'b0;
         clr_colour_q <= 8'h00;
         ctr_q        <= {CTR_W{1'b0}};
         pix_adr_q    <= {ADDR_W{1'b0}};
         pix_data_q   <= {DATA_W{1'b0}};
         pix_be_q     <= 2'b00;
         clr_busy_q   <= 1'b0;
         err_oob_q    <= 1'b0;
         bus_req_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         clr_active_q <= clr_active_d;
         clr_colour_q <= clr_colour_d;
         ctr_q        <= ctr_d;
         pix_adr_q    <= pix_adr_d;
         pix_data_q   <= pix_data_d;
         pix_be_q     <= pix_be_d;
         clr_busy_q   <= clr_busy_d;
         err_oob_q    <= err_oob_d;
         bus_req_q    <= (state_d != TOP_IDLE);
      end
   end

   cram_async_write #(
      .WR_CYCLES (WR_CYCLES)
   ) u_cram_wr (
      .clk_i      (clk),
      .rst_i      (rst),
      .start_i    (seq_start_s),
      .addr_i     (seq_adr_s),
      .data_i     (seq_data_s),
      .be_i       (seq_be_s),
      .hold_o     (seq_hold_s),
      .done_o     (wr_done),
      .mem_adr_o  (MemAdr),
      .db_out_o   (db_out),
      .db_oe_o    (db_oe),
      .mem_wr_n_o (MemWR),
      .cs_n_o     (RamCS),
      .lb_n_o     (RamLB),
      .ub_n_o     (RamUB)
   );

   assign px_ready = px_ready_s;
   assign clr_busy = clr_busy_q;
   assign err_oob  = err_oob_q;
   assign bus_req  = bus_req_q;
   assign MemOE    = 1'b1;
   assign RamAdv   = 1'b0;
   assign RamClk   = 1'b0;
   assign RamCRE   = 1'b0;

endmodule
